// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 31-instruction MIPS core: sequences fetch, decode,
// execute, memory and writeback from the one-hot decoded instruction word.
module multicycle_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      code,
  input  logic             zero,
  input  logic             ovf,
  input  logic             im_ack,
  input  logic             dm_ack,
  output logic             im_req,
  output logic             dm_req,
  output logic             dm_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       rf_dst_sel,
  output logic [1:0]       rf_wd_sel,
  output logic [3:0]       alu_op,
  output logic             alu_b_sel,
  output logic             imm_zext,
  output logic             shamt_sel,
  output logic [2:0]       state_o,
  output logic             trap,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam int unsigned OpAdd   = 0;
  localparam int unsigned OpAddu  = 1;
  localparam int unsigned OpSub   = 2;
  localparam int unsigned OpSubu  = 3;
  localparam int unsigned OpAnd   = 4;
  localparam int unsigned OpOr    = 5;
  localparam int unsigned OpXor   = 6;
  localparam int unsigned OpNor   = 7;
  localparam int unsigned OpSlt   = 8;
  localparam int unsigned OpSltu  = 9;
  localparam int unsigned OpSll   = 10;
  localparam int unsigned OpSrl   = 11;
  localparam int unsigned OpSra   = 12;
  localparam int unsigned OpSllv  = 13;
  localparam int unsigned OpSrlv  = 14;
  localparam int unsigned OpSrav  = 15;
  localparam int unsigned OpJr    = 16;
  localparam int unsigned OpAddi  = 17;
  localparam int unsigned OpAddiu = 18;
  localparam int unsigned OpAndi  = 19;
  localparam int unsigned OpOri   = 20;
  localparam int unsigned OpXori  = 21;
  localparam int unsigned OpLw    = 22;
  localparam int unsigned OpSw    = 23;
  localparam int unsigned OpBeq   = 24;
  localparam int unsigned OpBne   = 25;
  localparam int unsigned OpSlti  = 26;
  localparam int unsigned OpSltiu = 27;
  localparam int unsigned OpLui   = 28;
  localparam int unsigned OpJ     = 29;
  localparam int unsigned OpJal   = 30;

  // I-type instructions (incl. LW) write rt; SW additionally uses the immediate operand.
  localparam logic [31:0] ItypeMask = 32'h1C7E_0000;
  localparam logic [31:0] ImmBMask  = 32'h1CFE_0000;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluNor  = 4'd5;
  localparam logic [3:0] AluSlt  = 4'd6;
  localparam logic [3:0] AluSltu = 4'd7;
  localparam logic [3:0] AluSll  = 4'd8;
  localparam logic [3:0] AluSrl  = 4'd9;
  localparam logic [3:0] AluSra  = 4'd10;
  localparam logic [3:0] AluLui  = 4'd11;

  localparam logic [7:0] TmoLast = 8'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      code_q, code_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             trap_q, trap_d;
  logic             bus_err_q, bus_err_d;
  logic             retire;
  logic             code_valid;

  logic       alu_drive;
  logic [3:0] alu_op_c;
  logic       alu_b_c, zext_c, shamt_c, itype_c;
  logic       im_req_c, dm_req_c, dm_we_c, ir_we_c, pc_we_c, rf_we_c;
  logic [1:0] pc_sel_c, rf_dst_c, rf_wd_c;

  assign code_valid = ~code[31] && (code != 32'd0) && ((code & (code - 32'd1)) == 32'd0);

  always_comb begin
    alu_op_c = AluAdd;
    if (code_q[OpSub] | code_q[OpSubu] | code_q[OpBeq] | code_q[OpBne]) alu_op_c = AluSub;
    if (code_q[OpAnd] | code_q[OpAndi])                                 alu_op_c = AluAnd;
    if (code_q[OpOr]  | code_q[OpOri])                                  alu_op_c = AluOr;
    if (code_q[OpXor] | code_q[OpXori])                                 alu_op_c = AluXor;
    if (code_q[OpNor])                                                  alu_op_c = AluNor;
    if (code_q[OpSlt] | code_q[OpSlti])                                 alu_op_c = AluSlt;
    if (code_q[OpSltu] | code_q[OpSltiu])                               alu_op_c = AluSltu;
    if (code_q[OpSll] | code_q[OpSllv])                                 alu_op_c = AluSll;
    if (code_q[OpSrl] | code_q[OpSrlv])                                 alu_op_c = AluSrl;
    if (code_q[OpSra] | code_q[OpSrav])                                 alu_op_c = AluSra;
    if (code_q[OpLui])                                                  alu_op_c = AluLui;
    itype_c = |(code_q & ItypeMask);
    alu_b_c = |(code_q & ImmBMask);
    zext_c  = code_q[OpAndi] | code_q[OpOri] | code_q[OpXori];
    shamt_c = code_q[OpSll] | code_q[OpSrl] | code_q[OpSra];
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    tmo_d     = tmo_q;
    trap_d    = trap_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    alu_drive = 1'b0;
    im_req_c  = 1'b0;
    dm_req_c  = 1'b0;
    dm_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    pc_sel_c  = 2'd0;
    rf_we_c   = 1'b0;
    rf_dst_c  = 2'd0;
    rf_wd_c   = 2'd0;
    unique case (state_q)
      StFetch: begin
        im_req_c = 1'b1;
        if (im_ack) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = StDecode;
        end else if (tmo_q == TmoLast) begin
          state_d   = StTrap;
          trap_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StDecode: begin
        code_d = code;
        if (code_valid) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
          trap_d  = 1'b1;
        end
      end
      StExec: begin
        alu_drive = 1'b1;
        if (code_q[OpBeq] | code_q[OpBne]) begin
          if ((code_q[OpBeq] & zero) | (code_q[OpBne] & ~zero)) begin
            pc_we_c  = 1'b1;
            pc_sel_c = 2'd1;
          end
          state_d = StFetch;
          retire  = 1'b1;
        end else if (code_q[OpJ] | code_q[OpJr] | code_q[OpJal]) begin
          pc_we_c  = 1'b1;
          pc_sel_c = code_q[OpJr] ? 2'd3 : 2'd2;
          if (code_q[OpJal]) begin
            rf_we_c  = 1'b1;
            rf_dst_c = 2'd2;
            rf_wd_c  = 2'd2;
          end
          state_d = StFetch;
          retire  = 1'b1;
        end else if (code_q[OpLw] | code_q[OpSw]) begin
          state_d = StMem;
        end else if (ovf & (code_q[OpAdd] | code_q[OpSub] | code_q[OpAddi])) begin
          // Signed overflow suppresses writeback and does not count as retired.
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        alu_drive = 1'b1;
        dm_req_c  = 1'b1;
        dm_we_c   = code_q[OpSw];
        if (dm_ack) begin
          if (code_q[OpLw]) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end else if (tmo_q == TmoLast) begin
          state_d   = StTrap;
          trap_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StWb: begin
        alu_drive = 1'b1;
        rf_we_c   = 1'b1;
        rf_dst_c  = itype_c ? 2'd1 : 2'd0;
        rf_wd_c   = code_q[OpLw] ? 2'd1 : 2'd0;
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StTrap;
        trap_d  = 1'b1;
      end
    endcase
    if (state_d != state_q) tmo_d = 8'd0;
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      code_q    <= 32'd0;
      tmo_q     <= 8'd0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Every output is held low while reset is asserted.
  always_comb begin
    im_req     = ~rst & im_req_c;
    dm_req     = ~rst & dm_req_c;
    dm_we      = ~rst & dm_we_c;
    ir_we      = ~rst & ir_we_c;
    pc_we      = ~rst & pc_we_c;
    pc_sel     = rst ? 2'd0 : pc_sel_c;
    rf_we      = ~rst & rf_we_c;
    rf_dst_sel = rst ? 2'd0 : rf_dst_c;
    rf_wd_sel  = rst ? 2'd0 : rf_wd_c;
    alu_op     = (rst | ~alu_drive) ? 4'd0 : alu_op_c;
    alu_b_sel  = ~rst & alu_drive & alu_b_c;
    imm_zext   = ~rst & alu_drive & zext_c;
    shamt_sel  = ~rst & alu_drive & shamt_c;
    state_o    = rst ? 3'd0 : state_q;
    trap       = ~rst & trap_q;
    bus_err    = ~rst & bus_err_q;
    retired    = rst ? '0 : retired_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written trap/timeout/reset cases.
module tb_multicycle_ctrl;

  logic        clk, rst;
  logic [31:0] code;
  logic        zero, ovf, im_ack, dm_ack;
  logic        im_req, dm_req, dm_we, ir_we, pc_we, rf_we;
  logic [1:0]  pc_sel, rf_dst_sel, rf_wd_sel;
  logic [3:0]  alu_op;
  logic        alu_b_sel, imm_zext, shamt_sel, trap, bus_err;
  logic [2:0]  state_o;
  logic [31:0] retired;
  logic [23:0] got;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [31:0] C_ADD  = 32'h0000_0001;
  localparam logic [31:0] C_ADDU = 32'h0000_0002;
  localparam logic [31:0] C_SRA  = 32'h0000_1000;
  localparam logic [31:0] C_JR   = 32'h0001_0000;
  localparam logic [31:0] C_ANDI = 32'h0008_0000;
  localparam logic [31:0] C_LW   = 32'h0040_0000;
  localparam logic [31:0] C_SW   = 32'h0080_0000;
  localparam logic [31:0] C_BEQ  = 32'h0100_0000;
  localparam logic [31:0] C_LUI  = 32'h1000_0000;
  localparam logic [31:0] C_JAL  = 32'h4000_0000;

  multicycle_ctrl #(.ACK_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .code(code), .zero(zero), .ovf(ovf), .im_ack(im_ack),
    .dm_ack(dm_ack), .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .rf_dst_sel(rf_dst_sel),
    .rf_wd_sel(rf_wd_sel), .alu_op(alu_op), .alu_b_sel(alu_b_sel), .imm_zext(imm_zext),
    .shamt_sel(shamt_sel), .state_o(state_o), .trap(trap), .bus_err(bus_err),
    .retired(retired)
  );

  assign got = {state_o, im_req, dm_req, dm_we, ir_we, pc_we, pc_sel, rf_we, rf_dst_sel,
                rf_wd_sel, alu_op, alu_b_sel, imm_zext, shamt_sel, trap, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] code;
    logic        z, o, ia, da;
    logic [2:0]  st;
    logic [4:0]  stb;  // {im_req, dm_req, dm_we, ir_we, pc_we}
    logic [1:0]  pcs;
    logic        rfwe;
    logic [1:0]  dst, wd;
    logic [3:0]  alu;
    logic [2:0]  bzs;  // {alu_b_sel, imm_zext, shamt_sel}
    int unsigned ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] c, logic z, logic o, logic ia, logic da,
                              logic [2:0] st, logic [4:0] stb, logic [1:0] pcs,
                              logic rfwe, logic [1:0] dst, logic [1:0] wd,
                              logic [3:0] alu, logic [2:0] bzs, int unsigned ret);
    vec_t v;
    v.code = c; v.z = z; v.o = o; v.ia = ia; v.da = da; v.st = st; v.stb = stb;
    v.pcs = pcs; v.rfwe = rfwe; v.dst = dst; v.wd = wd; v.alu = alu; v.bzs = bzs;
    v.ret = ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; im_ack = 1'b0; dm_ack = 1'b0; zero = 1'b0; ovf = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] e;
    logic        bad;
    rst = 1'b1; code = 32'd0; zero = 1'b0; ovf = 1'b0; im_ack = 1'b0; dm_ack = 1'b0;
    @(negedge clk);
    #1;
    check("outputs_in_reset", {8'd0, got, retired}, 64'd0);

    // ADDU
    vecs.push_back(mk(C_ADDU, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(C_ADDU, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(C_ADDU, 0, 0, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 0));
    vecs.push_back(mk(C_ADDU, 0, 0, 0, 0, 4, 5'b00000, 0, 1, 0, 0, 0, 3'b000, 0));
    // LW, dm_ack after 3 waiting cycles
    vecs.push_back(mk(C_LW, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 1));
    vecs.push_back(mk(C_LW, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 1));
    vecs.push_back(mk(C_LW, 0, 0, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 0, 3'b100, 1));
    vecs.push_back(mk(C_LW, 0, 0, 0, 0, 3, 5'b01000, 0, 0, 0, 0, 0, 3'b100, 1));
    vecs.push_back(mk(C_LW, 0, 0, 0, 0, 3, 5'b01000, 0, 0, 0, 0, 0, 3'b100, 1));
    vecs.push_back(mk(C_LW, 0, 0, 0, 0, 3, 5'b01000, 0, 0, 0, 0, 0, 3'b100, 1));
    vecs.push_back(mk(C_LW, 0, 0, 0, 1, 3, 5'b01000, 0, 0, 0, 0, 0, 3'b100, 1));
    vecs.push_back(mk(C_LW, 0, 0, 0, 0, 4, 5'b00000, 0, 1, 1, 1, 0, 3'b100, 1));
    // SW
    vecs.push_back(mk(C_SW, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 2));
    vecs.push_back(mk(C_SW, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 2));
    vecs.push_back(mk(C_SW, 0, 0, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 0, 3'b100, 2));
    vecs.push_back(mk(C_SW, 0, 0, 0, 1, 3, 5'b01100, 0, 0, 0, 0, 0, 3'b100, 2));
    // BEQ taken, then not taken
    vecs.push_back(mk(C_BEQ, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 3));
    vecs.push_back(mk(C_BEQ, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 3));
    vecs.push_back(mk(C_BEQ, 1, 0, 0, 0, 2, 5'b00001, 1, 0, 0, 0, 1, 3'b000, 3));
    vecs.push_back(mk(C_BEQ, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 4));
    vecs.push_back(mk(C_BEQ, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 4));
    vecs.push_back(mk(C_BEQ, 0, 0, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 1, 3'b000, 4));
    // JAL
    vecs.push_back(mk(C_JAL, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 5));
    vecs.push_back(mk(C_JAL, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 5));
    vecs.push_back(mk(C_JAL, 0, 0, 0, 0, 2, 5'b00001, 2, 1, 2, 2, 0, 3'b000, 5));
    // ADD with overflow: no writeback, not retired
    vecs.push_back(mk(C_ADD, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 6));
    vecs.push_back(mk(C_ADD, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 6));
    vecs.push_back(mk(C_ADD, 0, 1, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 6));
    // ADDU with overflow still writes back
    vecs.push_back(mk(C_ADDU, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 6));
    vecs.push_back(mk(C_ADDU, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 6));
    vecs.push_back(mk(C_ADDU, 0, 1, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 6));
    vecs.push_back(mk(C_ADDU, 0, 0, 0, 0, 4, 5'b00000, 0, 1, 0, 0, 0, 3'b000, 6));
    // ANDI
    vecs.push_back(mk(C_ANDI, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 7));
    vecs.push_back(mk(C_ANDI, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 7));
    vecs.push_back(mk(C_ANDI, 0, 0, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 2, 3'b110, 7));
    vecs.push_back(mk(C_ANDI, 0, 0, 0, 0, 4, 5'b00000, 0, 1, 1, 0, 2, 3'b110, 7));
    // SRA
    vecs.push_back(mk(C_SRA, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 8));
    vecs.push_back(mk(C_SRA, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 8));
    vecs.push_back(mk(C_SRA, 0, 0, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 10, 3'b001, 8));
    vecs.push_back(mk(C_SRA, 0, 0, 0, 0, 4, 5'b00000, 0, 1, 0, 0, 10, 3'b001, 8));
    // JR
    vecs.push_back(mk(C_JR, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 9));
    vecs.push_back(mk(C_JR, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 9));
    vecs.push_back(mk(C_JR, 0, 0, 0, 0, 2, 5'b00001, 3, 0, 0, 0, 0, 3'b000, 9));
    // LUI after one fetch wait cycle
    vecs.push_back(mk(C_LUI, 0, 0, 0, 0, 0, 5'b10000, 0, 0, 0, 0, 0, 3'b000, 10));
    vecs.push_back(mk(C_LUI, 0, 0, 1, 0, 0, 5'b10011, 0, 0, 0, 0, 0, 3'b000, 10));
    vecs.push_back(mk(C_LUI, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0, 3'b000, 10));
    vecs.push_back(mk(C_LUI, 0, 0, 0, 0, 2, 5'b00000, 0, 0, 0, 0, 11, 3'b100, 10));
    vecs.push_back(mk(C_LUI, 0, 0, 0, 0, 4, 5'b00000, 0, 1, 1, 0, 11, 3'b100, 10));
    vecs.push_back(mk(C_LUI, 0, 0, 0, 0, 0, 5'b10000, 0, 0, 0, 0, 0, 3'b000, 11));

    do_reset();
    foreach (vecs[i]) begin
      code = vecs[i].code; zero = vecs[i].z; ovf = vecs[i].o;
      im_ack = vecs[i].ia; dm_ack = vecs[i].da;
      #1;
      e = {vecs[i].st, vecs[i].stb, vecs[i].pcs, vecs[i].rfwe, vecs[i].dst, vecs[i].wd,
           vecs[i].alu, vecs[i].bzs, 2'b00};
      check($sformatf("vec%0d", i), {got, retired}, {e, vecs[i].ret});
      cyc();
    end

    // Illegal code 0x3 in DECODE -> TRAP without bus error, no strobes.
    do_reset();
    code = 32'h3; im_ack = 1'b1;
    cyc();
    im_ack = 1'b0;
    cyc();
    #1;
    check("illegal_trap", {40'd0, got}, {40'd0, 3'd5, 19'd0, 2'b10});
    im_ack = 1'b1; dm_ack = 1'b1; zero = 1'b1; ovf = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      #1;
      if (got !== {3'd5, 19'd0, 2'b10}) bad = 1'b1;
    end
    check("trap_held_20", {63'd0, bad}, 64'd0);
    rst = 1'b1;
    #1;
    check("trap_reset_forces_0", {40'd0, got}, 64'd0);
    cyc();
    rst = 1'b0; im_ack = 1'b0; dm_ack = 1'b0; zero = 1'b0; ovf = 1'b0;
    #1;
    check("trap_reset_release", {40'd0, got}, {40'd0, 3'd0, 5'b10000, 16'd0});

    // code 0 is also illegal
    do_reset();
    code = 32'h0; im_ack = 1'b1;
    cyc();
    im_ack = 1'b0;
    cyc();
    #1;
    check("zero_code_trap", {61'd0, state_o}, {61'd0, 3'd5});
    check("zero_code_flags", {62'd0, trap, bus_err}, {62'd0, 2'b10});

    // Fetch timeout after 16 cycles without ack.
    do_reset();
    code = C_ADDU;
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (state_o !== 3'd0 || im_req !== 1'b1) bad = 1'b1;
      cyc();
    end
    #1;
    check("timeout_fetch_16", {63'd0, bad}, 64'd0);
    check("timeout_trap", {40'd0, got}, {40'd0, 3'd5, 19'd0, 2'b11});

    // Ack on the 16th cycle wins over the timeout.
    do_reset();
    for (int k = 0; k < 15; k++) cyc();
    im_ack = 1'b1;
    cyc();
    im_ack = 1'b0;
    #1;
    check("ack_at_limit", {58'd0, state_o, trap, bus_err, ir_we}, {58'd0, 3'd1, 3'b000});

    // Reset asserted in MEM.
    do_reset();
    code = C_ADDU; im_ack = 1'b1;
    cyc();
    im_ack = 1'b0;
    cyc(); cyc(); cyc();
    code = C_LW; im_ack = 1'b1;
    cyc();
    im_ack = 1'b0;
    cyc(); cyc();
    #1;
    check("in_mem_before_rst", {32'd0, 28'd0, state_o, dm_req, retired},
          {32'd0, 28'd0, 3'd3, 1'b1, 32'd1});
    rst = 1'b1;
    #1;
    check("rst_in_mem_forced", {40'd0, got}, 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("after_rst_in_mem", {28'd0, state_o, dm_req, retired}, {28'd0, 3'd0, 1'b0, 32'd0});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the 31-instruction MIPS core. It consumes the one-hot decoded instruction word from the instruction decoder and sequences fetch, decode, execute, memory and writeback.
- Drives the PC, IR, register-file, ALU-mux and data-memory controls, and handles req/ack handshakes to instruction and data memory.
- Sits between the decoder and the datapath. The datapath holds the PC, IR, register file and ALU; this block holds only state, the latched code, counters and an error flag.

Parameters:
- ACK_TIMEOUT, 16: maximum cycles waiting for im_ack/dm_ack before bus error (range 1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- code  in  32  one-hot decoder output. Bit mapping: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, 10 SLL, 11 SRL, 12 SRA, 13 SLLV, 14 SRLV, 15 SRAV, 16 JR, 17 ADDI, 18 ADDIU, 19 ANDI, 20 ORI, 21 XORI, 22 LW, 23 SW, 24 BEQ, 25 BNE, 26 SLTI, 27 SLTIU, 28 LUI, 29 J, 30 JAL. Bit 31 is unused.
- zero  in  1  ALU result == 0
- ovf  in  1  ALU signed overflow
- im_ack  in  1  instruction memory data valid
- dm_ack  in  1  data memory access complete
- im_req  out  1  instruction fetch request
- dm_req  out  1  data memory request
- dm_we  out  1  data memory write (SW)
- ir_we  out  1  load IR
- pc_we  out  1  write PC
- pc_sel  out  2  0 PC+4, 1 branch target, 2 jump target {PC[31:28],idx,00}, 3 rs
- rf_we  out  1  register-file write
- rf_dst_sel  out  2  0 rd, 1 rt, 2 r31
- rf_wd_sel  out  2  0 ALU, 1 memory data, 2 PC (already PC+4)
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI
- alu_b_sel  out  1  0 rt, 1 immediate
- imm_zext  out  1  1 zero-extend immediate (ANDI/ORI/XORI), else sign-extend
- shamt_sel  out  1  1 shift amount from shamt field (SLL/SRL/SRA), 0 from rs
- state_o  out  3  current state, for debug
- trap  out  1  sticky error flag
- bus_err  out  1  sticky; trap was caused by a handshake timeout
- retired  out  CNT_W  count of completed instructions

Behaviour:
- States, state_o encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset: state=FETCH, code_q=0, timeout counter=0, retired=0, trap=0, bus_err=0.
- All outputs are forced 0 while rst=1. Apart from that they are combinational from state, code_q and the inputs.
- FETCH:
  - im_req=1.
  - On im_ack: ir_we=1, pc_we=1, pc_sel=0, go to DECODE.
  - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT with no ack: go to TRAP with trap=1, bus_err=1.
  - The counter clears on every state change.
- DECODE (one cycle):
  - code_q <= code.
  - If code has zero bits set, more than one bit set, or bit 31 set: go to TRAP with trap=1 and bus_err=0.
  - Otherwise go to EXEC.
- EXEC (one cycle): ALU controls are driven from code_q.
  - Branches: BEQ (zero=1) or BNE (zero=0) gives pc_we=1, pc_sel=1. Then go to FETCH and retired+1.
  - J: pc_we=1, pc_sel=2, go to FETCH, retired+1.
  - JR: pc_we=1, pc_sel=3, go to FETCH, retired+1.
  - JAL: pc_we=1, pc_sel=2, rf_we=1, rf_dst_sel=2, rf_wd_sel=2, go to FETCH, retired+1.
  - LW/SW: alu_op=ADD, alu_b_sel=1, go to MEM.
  - Overflow: for ADD, SUB or ADDI with ovf=1, no write occurs; go to FETCH, retired unchanged.
  - All other instructions go to WB.
- MEM:
  - dm_req=1; dm_we=1 for SW. The ALU controls are held.
  - On dm_ack: LW goes to WB; SW goes to FETCH with retired+1.
  - Timeout is handled as in FETCH.
- WB:
  - rf_we=1 for one cycle, ALU controls held.
  - rf_dst_sel: 1 for I-type and LW, 0 for R-type.
  - rf_wd_sel: 1 for LW, else 0.
  - Go to FETCH, retired+1.
- ALU mapping:
  - ADD/ADDU/ADDI/ADDIU map to 0.
  - SUB/SUBU, BEQ and BNE map to 1.
  - SLT/SLTI map to 6; SLTU/SLTIU map to 7.
  - The logic ops and their immediate forms map to 2..5.
  - Shifts, including the V forms, map to 8..10. LUI maps to 11.
  - alu_b_sel=1 for all I-type instructions and LW/SW.
- TRAP:
  - All strobes are 0; state is held until rst.
  - trap and bus_err stay set.
- Reset mid-operation: takes effect on the next edge from any state. No pending strobe may be asserted in the cycle after reset.
- Simultaneous events: im_ack in the same cycle the timeout would expire counts as success. retired wraps modulo 2^CNT_W.
- Latency: ALU ops take 4 cycles plus fetch wait; LW takes 5 plus waits; SW takes 4 plus waits; branches and jumps take 3 plus fetch wait.

Test Plan:
- ADDU, im_ack immediate → states 0,1,2,4,0. rf_we=1 only in WB with rf_dst_sel=0, alu_op=0. retired 0→1.
- LW, dm_ack after 3 cycles → MEM held 4 cycles with dm_req=1, dm_we=0. WB has rf_wd_sel=1, rf_dst_sel=1. SW variant: dm_we=1, no rf_we, returns to FETCH.
- BEQ with zero=1 → pc_we=1, pc_sel=1 in EXEC. With zero=0 → pc_we=0 in EXEC. Both return to FETCH. JAL → rf_we=1, rf_dst_sel=2, rf_wd_sel=2, pc_sel=2.
- ADD with ovf=1 → no rf_we; FETCH next; retired unchanged. ADDU with ovf=1 still writes back.
- code=0x0 or 0x3 in DECODE → TRAP, trap=1, bus_err=0, no strobes for 20 cycles. rst → FETCH, trap=0.
- im_ack held low with ACK_TIMEOUT=16 → TRAP after 16 FETCH cycles with bus_err=1. Ack on the 16th cycle → DECODE. rst asserted in MEM → next cycle FETCH, dm_req=0, retired=0.
